// File: rtl/fpu_issue_scoreboard.sv
// FPU decode/issue stage: decodes FP instructions, scoreboards in-flight FP
// destinations, reserves the shared writeback port and serialises the divider.
module fpu_issue_scoreboard #(
  parameter int LAT_ADD  = 2,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MISC = 1,
  parameter int NREG     = 32,
  parameter int MAX_LAT  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              ALUop,
  input  logic [2:0]              funct3,
  input  logic [4:0]              funct7b6to2,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  input  logic [$clog2(NREG)-1:0] rd,
  input  logic                    flush,
  output logic                    issue_valid,
  output logic [6:0]              ALUControl,
  output logic                    FPURegWrite,
  output logic                    not_fpu_src_a,
  output logic                    illegal,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_rd,
  output logic                    wb_fpu
);
  localparam int RW = $clog2(NREG);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int DW = $clog2(LAT_DIV + 1);

  logic [6:0]    w_ctrl;
  logic          w_fpwr, w_nfa, w_ill, w_ls, w_use_rs2, w_is_div;
  logic [LW-1:0] w_lat;
  logic          w_track, w_hazard, w_fire, w_sched;

  logic [NREG-1:0] r_pend;
  logic [DW-1:0]   r_div;
  logic            r_issue, r_fpwr, r_nfa, r_ill;
  logic [6:0]      r_ctrl;

  // Writeback delay line: slot d holds the writeback due d cycles from now.
  logic          w_slot_v   [MAX_LAT+1];
  logic [RW-1:0] w_slot_rd  [MAX_LAT+1];
  logic          w_slot_fpu [MAX_LAT+1];

  always_comb begin
    w_ctrl    = '0;
    w_fpwr    = 1'b1;
    w_nfa     = 1'b0;
    w_ill     = 1'b0;
    w_ls      = 1'b0;
    w_use_rs2 = 1'b0;
    w_is_div  = 1'b0;
    w_lat     = LW'(LAT_MISC);
    if (ALUop == 2'b00) begin
      w_ls = 1'b1;
    end else begin
      case (funct7b6to2)
        5'b00000: begin w_ctrl = 7'b1000000; w_use_rs2 = 1'b1; w_lat = LW'(LAT_ADD); end
        5'b00001: begin w_ctrl = 7'b1000001; w_use_rs2 = 1'b1; w_lat = LW'(LAT_ADD); end
        5'b00010: begin w_ctrl = 7'b1000010; w_use_rs2 = 1'b1; w_lat = LW'(LAT_MUL); end
        5'b00011: begin
          w_ctrl = 7'b1000011; w_use_rs2 = 1'b1; w_lat = LW'(LAT_DIV); w_is_div = 1'b1;
        end
        5'b01011: begin w_ctrl = 7'b1000111; w_lat = LW'(LAT_DIV); w_is_div = 1'b1; end
        5'b10100: begin
          w_fpwr    = 1'b0;
          w_use_rs2 = 1'b1;
          case (funct3)
            3'b010:  w_ctrl = 7'b1000100;
            3'b001:  w_ctrl = 7'b1000101;
            3'b000:  w_ctrl = 7'b1000110;
            default: w_ill  = 1'b1;
          endcase
        end
        5'b00100: begin
          w_use_rs2 = 1'b1;
          case (funct3)
            3'b000:  w_ctrl = 7'b0100010;
            3'b001:  w_ctrl = 7'b0100011;
            default: w_ill  = 1'b1;
          endcase
        end
        5'b11000: begin w_ctrl = 7'b1001111; w_fpwr = 1'b0; w_lat = LW'(LAT_CVT); end
        5'b11010: begin w_ctrl = 7'b1010111; w_nfa = 1'b1; w_lat = LW'(LAT_CVT); end
        5'b11100: begin w_ctrl = 7'b0100001; w_fpwr = 1'b0; end
        5'b11110: begin w_ctrl = 7'b0100001; w_nfa = 1'b1; end
        default:  w_ill = 1'b1;
      endcase
    end
    if (w_ill) begin
      w_ctrl = '0;
      w_fpwr = 1'b0;
      w_nfa  = 1'b0;
    end
  end

  // Load/store and illegal encodings never wait on the scoreboard.
  assign w_track  = !w_ls && !w_ill;
  assign w_hazard = (!w_nfa && r_pend[rs1]) || (w_use_rs2 && r_pend[rs2]) ||
                    (w_fpwr && r_pend[rd]) || w_slot_v[w_lat] ||
                    (w_is_div && (r_div != '0));
  assign in_ready = !flush && (!w_track || !w_hazard);
  assign w_fire   = in_valid && in_ready;
  assign w_sched  = w_fire && w_track;

  assign w_slot_v[MAX_LAT]   = 1'b0;
  assign w_slot_rd[MAX_LAT]  = '0;
  assign w_slot_fpu[MAX_LAT] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LAT; gi++) begin : g_slot
      logic          r_v, r_fpu;
      logic [RW-1:0] r_rd;
      logic          w_ins;
      assign w_ins = w_sched && (w_lat == LW'(gi + 1));
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0; r_rd <= '0; r_fpu <= 1'b0;
        end else if (flush) begin
          r_v <= 1'b0; r_rd <= '0; r_fpu <= 1'b0;
        end else if (w_ins) begin
          r_v <= 1'b1; r_rd <= rd; r_fpu <= w_fpwr;
        end else begin
          r_v <= w_slot_v[gi+1]; r_rd <= w_slot_rd[gi+1]; r_fpu <= w_slot_fpu[gi+1];
        end
      end
      assign w_slot_v[gi]   = r_v;
      assign w_slot_rd[gi]  = r_rd;
      assign w_slot_fpu[gi] = r_fpu;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0; r_div <= '0;
      r_issue <= 1'b0; r_ctrl <= '0; r_fpwr <= 1'b0; r_nfa <= 1'b0; r_ill <= 1'b0;
    end else if (flush) begin
      r_pend <= '0; r_div <= '0;
      r_issue <= 1'b0; r_ctrl <= '0; r_fpwr <= 1'b0; r_nfa <= 1'b0; r_ill <= 1'b0;
    end else begin
      r_issue <= w_fire && !w_ill;
      r_ill   <= w_fire && w_ill;
      r_ctrl  <= w_fire ? w_ctrl : 7'd0;
      r_fpwr  <= w_fire && w_fpwr;
      r_nfa   <= w_fire && w_nfa;
      // The issue cycle counts as the first busy cycle of the divider.
      if (w_sched && w_is_div)
        r_div <= DW'(LAT_DIV - 1);
      else if (r_div != '0)
        r_div <= r_div - DW'(1);
      if (w_slot_v[0] && w_slot_fpu[0])
        r_pend[w_slot_rd[0]] <= 1'b0;
      if (w_sched && w_fpwr)
        r_pend[rd] <= 1'b1;
    end
  end

  assign issue_valid   = r_issue && !flush;
  assign ALUControl    = flush ? 7'd0 : r_ctrl;
  assign FPURegWrite   = r_fpwr && !flush;
  assign not_fpu_src_a = r_nfa && !flush;
  assign illegal       = r_ill && !flush;
  assign wb_valid      = w_slot_v[0] && !flush;
  assign wb_rd         = wb_valid ? w_slot_rd[0] : '0;
  assign wb_fpu        = wb_valid && w_slot_fpu[0];
endmodule

// File: tb/tb_fpu_issue_scoreboard.sv
// Bench for fpu_issue_scoreboard: directed scenarios with literal expectations
// plus random traffic checked each cycle against an absolute-time schedule model.
module tb_fpu_issue_scoreboard;
  localparam int LAT_ADD = 2, LAT_MUL = 2, LAT_DIV = 10, LAT_CVT = 2, LAT_MISC = 1;
  localparam int NREG = 32, MAX_LAT = 10;
  localparam int RW = $clog2(NREG);

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush;
  logic [1:0] ALUop;
  logic [2:0] funct3;
  logic [4:0] funct7b6to2;
  logic [RW-1:0] rs1, rs2, rd, wb_rd;
  logic issue_valid, FPURegWrite, not_fpu_src_a, illegal, wb_valid, wb_fpu;
  logic [6:0] ALUControl;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_issue_scoreboard #(
    .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_CVT(LAT_CVT),
    .LAT_MISC(LAT_MISC), .NREG(NREG), .MAX_LAT(MAX_LAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUop(ALUop),
    .funct3(funct3), .funct7b6to2(funct7b6to2), .rs1(rs1), .rs2(rs2), .rd(rd),
    .flush(flush), .issue_valid(issue_valid), .ALUControl(ALUControl),
    .FPURegWrite(FPURegWrite), .not_fpu_src_a(not_fpu_src_a), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fpu(wb_fpu)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [6:0] ctrl;
    bit fpwr, nfa, ill, ls, u2, dv;
    int lat;
  } dec_t;

  // Instruction table: what each encoding means to the issue stage.
  function automatic dec_t decode(logic [1:0] op, logic [2:0] f3, logic [4:0] f7);
    dec_t d;
    d.ctrl = 7'd0; d.fpwr = 1; d.nfa = 0; d.ill = 0; d.ls = 0; d.u2 = 0; d.dv = 0;
    d.lat = LAT_MISC;
    if (op == 2'b00) begin
      d.ls = 1;
      return d;
    end
    if (f7 == 5'b00000)      begin d.ctrl = 7'b1000000; d.u2 = 1; d.lat = LAT_ADD; end
    else if (f7 == 5'b00001) begin d.ctrl = 7'b1000001; d.u2 = 1; d.lat = LAT_ADD; end
    else if (f7 == 5'b00010) begin d.ctrl = 7'b1000010; d.u2 = 1; d.lat = LAT_MUL; end
    else if (f7 == 5'b00011) begin d.ctrl = 7'b1000011; d.u2 = 1; d.lat = LAT_DIV; d.dv = 1; end
    else if (f7 == 5'b01011) begin d.ctrl = 7'b1000111; d.lat = LAT_DIV; d.dv = 1; end
    else if (f7 == 5'b10100) begin
      d.fpwr = 0; d.u2 = 1;
      if (f3 == 3'b010) d.ctrl = 7'b1000100;
      else if (f3 == 3'b001) d.ctrl = 7'b1000101;
      else if (f3 == 3'b000) d.ctrl = 7'b1000110;
      else d.ill = 1;
    end
    else if (f7 == 5'b00100) begin
      d.u2 = 1;
      if (f3 == 3'b000) d.ctrl = 7'b0100010;
      else if (f3 == 3'b001) d.ctrl = 7'b0100011;
      else d.ill = 1;
    end
    else if (f7 == 5'b11000) begin d.ctrl = 7'b1001111; d.fpwr = 0; d.lat = LAT_CVT; end
    else if (f7 == 5'b11010) begin d.ctrl = 7'b1010111; d.nfa = 1; d.lat = LAT_CVT; end
    else if (f7 == 5'b11100) begin d.ctrl = 7'b0100001; d.fpwr = 0; end
    else if (f7 == 5'b11110) begin d.ctrl = 7'b0100001; d.nfa = 1; end
    else d.ill = 1;
    if (d.ill) begin d.ctrl = 7'd0; d.fpwr = 0; d.nfa = 0; end
    return d;
  endfunction

  // Model: pending bits, writebacks keyed by the absolute cycle they happen in.
  bit          m_pend [NREG];
  int          m_sched_rd [longint];
  bit          m_sched_fpu [longint];
  longint      now = 0;
  longint      m_div_free = 0;
  bit          m_iv, m_fpwr, m_nfa, m_ill;
  logic [6:0]  m_ctrl;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    m_sched_rd.delete();
    m_sched_fpu.delete();
    m_div_free = 0;
    m_iv = 0; m_fpwr = 0; m_nfa = 0; m_ill = 0; m_ctrl = 7'd0;
  endtask

  function automatic bit ready_fn(dec_t d);
    if (flush) return 0;
    if (d.ls || d.ill) return 1;
    if (!d.nfa && m_pend[rs1]) return 0;
    if (d.u2 && m_pend[rs2]) return 0;
    if (d.fpwr && m_pend[rd]) return 0;
    if (m_sched_rd.exists(now + d.lat)) return 0;
    if (d.dv && now < m_div_free) return 0;
    return 1;
  endfunction

  always @(negedge clk) begin : cmp
    dec_t d;
    bit rdy, fire, wbv, wfpu;
    int wrd;
    d = decode(ALUop, funct3, funct7b6to2);
    if (rst) model_clear();
    rdy  = ready_fn(d);
    wbv  = !flush && m_sched_rd.exists(now);
    wrd  = wbv ? m_sched_rd[now] : 0;
    wfpu = wbv && m_sched_fpu[now];
    chk("m_in_ready", in_ready, rdy);
    chk("m_issue_valid", issue_valid, m_iv && !flush);
    chk("m_ALUControl", ALUControl, flush ? 7'd0 : m_ctrl);
    chk("m_FPURegWrite", FPURegWrite, m_fpwr && !flush);
    chk("m_not_fpu_src_a", not_fpu_src_a, m_nfa && !flush);
    chk("m_illegal", illegal, m_ill && !flush);
    chk("m_wb_valid", wb_valid, wbv);
    chk("m_wb_rd", wb_rd, wrd);
    chk("m_wb_fpu", wb_fpu, wfpu);
    if (rst || flush) begin
      model_clear();
    end else begin
      fire = in_valid && rdy;
      if (m_sched_rd.exists(now)) begin
        if (m_sched_fpu[now]) m_pend[m_sched_rd[now]] = 0;
        m_sched_rd.delete(now);
        m_sched_fpu.delete(now);
      end
      m_iv   = fire && !d.ill;
      m_ill  = fire && d.ill;
      m_ctrl = (fire && !d.ill) ? d.ctrl : 7'd0;
      m_fpwr = fire && d.fpwr;
      m_nfa  = fire && d.nfa;
      if (fire && !d.ls && !d.ill) begin
        m_sched_rd[now + d.lat]  = int'(rd);
        m_sched_fpu[now + d.lat] = d.fpwr;
        if (d.fpwr) m_pend[rd] = 1;
        if (d.dv) m_div_free = now + LAT_DIV;
      end
    end
    now++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic [4:0] f7,
                        input int a, input int b, input int d);
    in_valid = 1'b1; ALUop = op; funct3 = f3; funct7b6to2 = f7;
    rs1 = RW'(a); rs2 = RW'(b); rd = RW'(d);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  logic [4:0] f7tab [12] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd20, 5'd4, 5'd24,
                             5'd26, 5'd28, 5'd30, 5'd20};

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ALUop = 2'b00; funct3 = 3'd0;
    funct7b6to2 = 5'd0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #2;
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_ALUControl", ALUControl, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_FPURegWrite", FPURegWrite, 0);
    idle(2);

    // Reset in the middle of an FDIV
    tick(); set_op(2'b10, 3'b000, 5'b00011, 1, 2, 3); #2; chk("rm_fdiv_rdy", in_ready, 1);
    tick(); in_valid = 1'b0;
    tick(); tick();
    tick(); rst = 1'b1; #2;
    chk("rm_iv", issue_valid, 0); chk("rm_wbv", wb_valid, 0); chk("rm_ctrl", ALUControl, 0);
    tick(); rst = 1'b0; set_op(2'b10, 3'b000, 5'b00011, 1, 2, 3); #2;
    chk("rm_fdiv2_rdy", in_ready, 1);
    tick(); in_valid = 1'b0; #2; chk("rm_fdiv2_iv", issue_valid, 1);
    idle(14);

    // FADD -> dependent FMUL
    tick(); set_op(2'b10, 3'b000, 5'b00000, 1, 2, 5); #2; chk("fadd_rdy", in_ready, 1);
    tick(); set_op(2'b10, 3'b000, 5'b00010, 5, 6, 8); #2;
    chk("fadd_iv", issue_valid, 1); chk("fadd_ctrl", ALUControl, 7'b1000000);
    chk("raw_t1", in_ready, 0);
    tick(); #2;
    chk("fadd_wbv", wb_valid, 1); chk("fadd_wbrd", wb_rd, 5); chk("fadd_wbfpu", wb_fpu, 1);
    chk("raw_t2", in_ready, 0);
    tick(); #2; chk("raw_t3", in_ready, 1);
    tick(); in_valid = 1'b0; #2;
    chk("fmul_iv", issue_valid, 1); chk("fmul_ctrl", ALUControl, 7'b1000010);
    idle(12);

    // FDIV then FSQRT on the shared divider
    tick(); set_op(2'b10, 3'b000, 5'b00011, 3, 4, 1); #2; chk("fdiv_rdy", in_ready, 1);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) set_op(2'b10, 3'b000, 5'b01011, 5, 1, 2);
      if (c == 11) in_valid = 1'b0;
      #2;
      if (c <= 10) chk("sqrt_rdy", in_ready, (c == 10));
      if (c == 10) begin chk("div_wb1_v", wb_valid, 1); chk("div_wb1_rd", wb_rd, 1); end
      if (c == 20) begin chk("div_wb2_v", wb_valid, 1); chk("div_wb2_rd", wb_rd, 2); end
    end
    idle(4);

    // Writeback port conflict
    tick(); set_op(2'b10, 3'b000, 5'b00010, 1, 2, 4); #2;
    tick(); set_op(2'b10, 3'b000, 5'b00100, 9, 10, 6); #2; chk("sgnj_stall", in_ready, 0);
    tick(); #2;
    chk("sgnj_rdy", in_ready, 1); chk("wbc_wb1_v", wb_valid, 1); chk("wbc_wb1_rd", wb_rd, 4);
    tick(); in_valid = 1'b0; #2;
    chk("wbc_wb2_v", wb_valid, 1); chk("wbc_wb2_rd", wb_rd, 6);
    chk("sgnj_ctrl", ALUControl, 7'b0100010);
    idle(6);

    // Compare writes integer file; illegal compare funct3
    tick(); set_op(2'b10, 3'b010, 5'b10100, 1, 2, 7); #2; chk("feq_rdy", in_ready, 1);
    tick(); set_op(2'b10, 3'b000, 5'b00000, 7, 7, 7); #2;
    chk("feq_ctrl", ALUControl, 7'b1000100); chk("feq_fpwr", FPURegWrite, 0);
    chk("feq_wbv", wb_valid, 1); chk("feq_wbfpu", wb_fpu, 0); chk("feq_wbrd", wb_rd, 7);
    chk("feq_no_pend", in_ready, 1);
    tick(); set_op(2'b10, 3'b011, 5'b10100, 1, 2, 9); #2; chk("ill_rdy", in_ready, 1);
    tick(); in_valid = 1'b0; #2;
    chk("ill_flag", illegal, 1); chk("ill_iv", issue_valid, 0);
    idle(6);

    // Flush with three ops in flight
    tick(); set_op(2'b10, 3'b000, 5'b00011, 1, 2, 10); #2; chk("fl_fdiv_rdy", in_ready, 1);
    tick(); set_op(2'b10, 3'b000, 5'b00000, 3, 4, 11); #2;
    tick(); set_op(2'b10, 3'b000, 5'b00010, 5, 6, 12); #2;
    tick(); in_valid = 1'b0; flush = 1'b1; #2;
    chk("fl_wbv", wb_valid, 0); chk("fl_rdy", in_ready, 0); chk("fl_iv", issue_valid, 0);
    tick(); flush = 1'b0; set_op(2'b10, 3'b000, 5'b00011, 10, 11, 12); #2;
    chk("fl_after_rdy", in_ready, 1);
    tick(); in_valid = 1'b0; #2;
    chk("fl_after_iv", issue_valid, 1); chk("fl_after_ctrl", ALUControl, 7'b1000011);
    idle(14);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst   = (rst == 1'b0) && ($urandom_range(0, 399) == 0);
      flush = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      ALUop = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      funct7b6to2 = ($urandom_range(0, 9) < 9) ? f7tab[$urandom_range(0, 11)] : 5'($urandom);
      funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      rs1 = RW'($urandom_range(0, 7));
      rs2 = RW'($urandom_range(0, 7));
      rd  = RW'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0; flush = 1'b0;
    idle(14);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
